// File: rtl/i2c_slave_ctrl_pkg.sv
// Shared types and constants for the I2C slave register controller.
package i2c_slave_ctrl_pkg;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 8;
    localparam int RO_REGS    = 1;

    typedef enum logic [2:0] {
        IDLE,
        GET_POINTER,
        WRITE_DATA,
        READ_FETCH,
        READ_READY,
        READ_DONE
    } state_t;

    // Next register index, wrapping at the register count (a power of two).
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned num_regs);
        return (ptr + 1) % num_regs;
    endfunction

endpackage

// File: rtl/i2c_reg_pointer.sv
// Register pointer: loadable, auto-incrementing, wraps at NUM_REGS.
module i2c_reg_pointer
    import i2c_slave_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = i2c_slave_ctrl_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = i2c_slave_ctrl_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_value;
        end else if (inc) begin
            ptr <= ADDR_WIDTH'(ptr_next(32'(ptr), NUM_REGS));
        end
    end

endmodule

// File: rtl/i2c_slave_register_controller.sv
// Maps byte-level I2C slave transactions onto a synchronous register RAM.
// Build option: define I2C_SLAVE_WRITE_PROTECT_EN to make registers 0..RO_REGS-1 read-only.
module i2c_slave_register_controller
    import i2c_slave_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = i2c_slave_ctrl_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = i2c_slave_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = i2c_slave_ctrl_pkg::DATA_WIDTH,
    parameter int RO_REGS    = i2c_slave_ctrl_pkg::RO_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Slave_Start,
    input  logic                  Slave_Stop,
    input  logic                  Slave_AddrMatch,
    input  logic                  Slave_RW,
    input  logic                  Slave_RxValid,
    input  logic [DATA_WIDTH-1:0] Slave_RxData,
    input  logic                  Slave_TxReq,
    input  logic                  Slave_MasterNack,
    output logic [DATA_WIDTH-1:0] Slave_TxData,
    output logic                  Slave_TxValid,
    output logic [ADDR_WIDTH-1:0] RAM_RADD,
    input  logic [DATA_WIDTH-1:0] RAM_RDOUT,
    output logic [ADDR_WIDTH-1:0] RAM_WADD,
    output logic [DATA_WIDTH-1:0] RAM_DIN,
    output logic                  RAM_W,
    output logic [ADDR_WIDTH-1:0] Reg_Pointer,
    output logic                  Busy
);

`ifdef I2C_SLAVE_WRITE_PROTECT_EN
    localparam bit WRITE_PROTECT = 1'b1;
`else
    localparam bit WRITE_PROTECT = 1'b0;
`endif

    state_t state;
    logic   fetch_phase;
    logic   tx_pending;

    // Stop and Start outrank AddrMatch, which outranks every data event.
    logic abort, data_ok, serve, ptr_load, ptr_inc, writable;

    assign abort    = Slave_Stop || (Slave_Start && state != IDLE);
    assign data_ok  = !Slave_Stop && !Slave_Start && !Slave_AddrMatch;
    assign serve    = (state == READ_READY) && (Slave_TxReq || tx_pending)
                      && !Slave_MasterNack && data_ok;
    assign ptr_load = (state == GET_POINTER) && Slave_RxValid && data_ok;
    assign ptr_inc  = ((state == WRITE_DATA) && Slave_RxValid && data_ok) || serve;
    assign writable = !(WRITE_PROTECT && int'(Reg_Pointer) < RO_REGS);

    i2c_reg_pointer #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_pointer (
        .clk       (clk),
        .reset     (reset),
        .load      (ptr_load),
        .load_value(Slave_RxData[ADDR_WIDTH-1:0]),
        .inc       (ptr_inc),
        .ptr       (Reg_Pointer)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            fetch_phase   <= 1'b0;
            tx_pending    <= 1'b0;
            Slave_TxData  <= '0;
            Slave_TxValid <= 1'b0;
            RAM_RADD      <= '0;
            RAM_WADD      <= '0;
            RAM_DIN       <= '0;
            RAM_W         <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each assertion is exactly one clock wide.
            RAM_W         <= 1'b0;
            Slave_TxValid <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                Busy       <= 1'b0;
                tx_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Slave_AddrMatch) begin
                            Busy <= 1'b1;
                            if (Slave_RW) begin
                                state       <= READ_FETCH;
                                fetch_phase <= 1'b0;
                                tx_pending  <= 1'b0;
                                RAM_RADD    <= Reg_Pointer;
                            end else begin
                                state <= GET_POINTER;
                            end
                        end
                    end
                    GET_POINTER: begin
                        if (ptr_load) state <= WRITE_DATA;
                    end
                    WRITE_DATA: begin
                        if (ptr_inc) begin
                            RAM_WADD <= Reg_Pointer;
                            RAM_DIN  <= Slave_RxData;
                            RAM_W    <= writable;
                        end
                    end
                    READ_FETCH: begin
                        if (data_ok && Slave_MasterNack) begin
                            state      <= READ_DONE;
                            tx_pending <= 1'b0;
                        end else begin
                            if (data_ok && Slave_TxReq) tx_pending <= 1'b1;
                            // Phase 0 presents the address; phase 1 sees the RAM data.
                            fetch_phase <= ~fetch_phase;
                            if (fetch_phase) begin
                                Slave_TxData <= RAM_RDOUT;
                                state        <= READ_READY;
                            end
                        end
                    end
                    READ_READY: begin
                        if (data_ok && Slave_MasterNack) begin
                            state      <= READ_DONE;
                            tx_pending <= 1'b0;
                        end else if (serve) begin
                            Slave_TxValid <= 1'b1;
                            tx_pending    <= 1'b0;
                            RAM_RADD      <= ADDR_WIDTH'(ptr_next(32'(Reg_Pointer), NUM_REGS));
                            fetch_phase   <= 1'b0;
                            state         <= READ_FETCH;
                        end
                    end
                    READ_DONE: ;
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_register_controller.sv
// Directed self-checking bench for i2c_slave_register_controller with a behavioural sync RAM.
module tb_i2c_slave_register_controller;

    logic       clk;
    logic       reset;
    logic       Slave_Start, Slave_Stop, Slave_AddrMatch, Slave_RW;
    logic       Slave_RxValid, Slave_TxReq, Slave_MasterNack;
    logic [7:0] Slave_RxData, Slave_TxData, RAM_RDOUT, RAM_DIN;
    logic       Slave_TxValid, RAM_W, Busy;
    logic [4:0] RAM_RADD, RAM_WADD, Reg_Pointer;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [32];

    i2c_slave_register_controller dut (
        .clk             (clk),
        .reset           (reset),
        .Slave_Start     (Slave_Start),
        .Slave_Stop      (Slave_Stop),
        .Slave_AddrMatch (Slave_AddrMatch),
        .Slave_RW        (Slave_RW),
        .Slave_RxValid   (Slave_RxValid),
        .Slave_RxData    (Slave_RxData),
        .Slave_TxReq     (Slave_TxReq),
        .Slave_MasterNack(Slave_MasterNack),
        .Slave_TxData    (Slave_TxData),
        .Slave_TxValid   (Slave_TxValid),
        .RAM_RADD        (RAM_RADD),
        .RAM_RDOUT       (RAM_RDOUT),
        .RAM_WADD        (RAM_WADD),
        .RAM_DIN         (RAM_DIN),
        .RAM_W           (RAM_W),
        .Reg_Pointer     (Reg_Pointer),
        .Busy            (Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (RAM_W) mem[RAM_WADD] <= RAM_DIN;
        RAM_RDOUT <= mem[RAM_RADD];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_match(input logic rw);
        Slave_AddrMatch = 1'b1;
        Slave_RW        = rw;
        tick();
        Slave_AddrMatch = 1'b0;
        Slave_RW        = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        Slave_RxData  = b;
        Slave_RxValid = 1'b1;
        tick();
        Slave_RxValid = 1'b0;
    endtask

    // Data byte in WRITE_DATA: expect a single write strobe at the given address.
    task automatic rx_write(input string tag, input logic [7:0] b, input logic [4:0] addr, input logic exp_w);
        rx_byte(b);
        check({tag, "_w"}, RAM_W, exp_w);
        if (exp_w) begin
            check({tag, "_wadd"}, RAM_WADD, addr);
            check({tag, "_din"}, RAM_DIN, b);
        end
        tick();
        check({tag, "_w_low"}, RAM_W, 1'b0);
    endtask

    task automatic bus_event(input logic stop, input logic start, input logic nack);
        Slave_Stop       = stop;
        Slave_Start      = start;
        Slave_MasterNack = nack;
        tick();
        Slave_Stop       = 1'b0;
        Slave_Start      = 1'b0;
        Slave_MasterNack = 1'b0;
    endtask

    task automatic tx_req(input string tag, input logic [7:0] exp_data);
        Slave_TxReq = 1'b1;
        tick();
        Slave_TxReq = 1'b0;
        check({tag, "_valid"}, Slave_TxValid, 1'b1);
        check({tag, "_data"}, Slave_TxData, exp_data);
        tick();
        check({tag, "_valid_low"}, Slave_TxValid, 1'b0);
        tick();
    endtask

    initial begin
        int lat, pulses, seen;
        logic [7:0] early_data;

        reset = 1'b0;
        Slave_Start = 0; Slave_Stop = 0; Slave_AddrMatch = 0; Slave_RW = 0;
        Slave_RxValid = 0; Slave_RxData = 0; Slave_TxReq = 0; Slave_MasterNack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ptr", Reg_Pointer, 5'd0);
        check("rst_busy", Busy, 1'b0);
        check("rst_outs", {Slave_TxData, Slave_TxValid, RAM_RADD, RAM_WADD, RAM_DIN, RAM_W}, 32'd0);
        reset = 1'b1;
        tick();

        // Write burst wrapping past register 31.
        addr_match(1'b0);
        check("wr_busy", Busy, 1'b1);
        rx_byte(8'h1E);
        check("wr_ptr_load_no_w", RAM_W, 1'b0);
        check("wr_ptr_load", Reg_Pointer, 5'd30);
        rx_write("wr_aa", 8'hAA, 5'd30, 1'b1);
        rx_write("wr_bb", 8'hBB, 5'd31, 1'b1);
        rx_write("wr_cc", 8'hCC, 5'd0, 1'b1);
        check("wr_ptr_wrap", Reg_Pointer, 5'd1);
        bus_event(1'b1, 1'b0, 1'b0);
        check("wr_stop_busy", Busy, 1'b0);
        check("wr_stop_ptr", Reg_Pointer, 5'd1);
        check("wr_mem30", mem[30], 8'hAA);
        check("wr_mem0", mem[0], 8'hCC);

        // Preload registers 5..8, then rewind pointer to 5.
        addr_match(1'b0);
        rx_byte(8'h05);
        rx_write("pre_11", 8'h11, 5'd5, 1'b1);
        rx_write("pre_22", 8'h22, 5'd6, 1'b1);
        rx_write("pre_33", 8'h33, 5'd7, 1'b1);
        rx_write("pre_44", 8'h44, 5'd8, 1'b1);
        bus_event(1'b1, 1'b0, 1'b0);
        addr_match(1'b0);
        rx_byte(8'h05);
        bus_event(1'b1, 1'b0, 1'b0);
        check("pre_ptr", Reg_Pointer, 5'd5);

        // Streaming read with prefetch, then master NACK.
        addr_match(1'b1);
        check("rd_radd", RAM_RADD, 5'd5);
        tick();
        tick();
        check("rd_prefetch", Slave_TxData, 8'h11);
        tx_req("rd0", 8'h11);
        check("rd0_ptr", Reg_Pointer, 5'd6);
        tx_req("rd1", 8'h22);
        tx_req("rd2", 8'h33);
        check("rd_ptr", Reg_Pointer, 5'd8);
        bus_event(1'b0, 1'b0, 1'b1);
        seen = 0;
        Slave_TxReq = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (Slave_TxValid) seen++;
        end
        Slave_TxReq = 1'b0;
        check("done_no_valid", seen, 0);
        check("done_ptr", Reg_Pointer, 5'd8);
        check("done_busy", Busy, 1'b1);
        bus_event(1'b1, 1'b0, 1'b0);
        check("done_stop_busy", Busy, 1'b0);

        // TxReq arriving while the first byte is still being fetched.
        addr_match(1'b1);
        Slave_TxReq = 1'b1;
        tick();
        Slave_TxReq = 1'b0;
        lat = 0; pulses = 0; early_data = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            if (Slave_TxValid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    early_data = Slave_TxData;
                end
            end
            tick();
        end
        check("early_latency_ok", (lat >= 1 && lat <= 3), 1'b1);
        check("early_pulses", pulses, 1);
        check("early_data", early_data, 8'h44);
        check("early_ptr", Reg_Pointer, 5'd9);
        bus_event(1'b1, 1'b0, 1'b0);

        // Pointer write followed by repeated-start read.
        addr_match(1'b0);
        rx_byte(8'h03);
        rx_write("rs_5a", 8'h5A, 5'd3, 1'b1);
        bus_event(1'b1, 1'b0, 1'b0);
        addr_match(1'b0);
        rx_byte(8'hE3);
        check("rs_ptr_upper_ignored", Reg_Pointer, 5'd3);
        bus_event(1'b0, 1'b1, 1'b0);
        check("rs_start_idle", Busy, 1'b0);
        addr_match(1'b1);
        tick();
        tick();
        tx_req("rs_rd", 8'h5A);
        bus_event(1'b1, 1'b1, 1'b0);
        check("rs_stop_start_idle", Busy, 1'b0);
        check("rs_ptr", Reg_Pointer, 5'd4);

        // Register 0 writes: suppressed only when write protection is built in.
        addr_match(1'b0);
        rx_byte(8'h00);
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
        rx_write("wp_55", 8'h55, 5'd0, 1'b0);
`else
        rx_write("wp_55", 8'h55, 5'd0, 1'b1);
`endif
        rx_write("wp_66", 8'h66, 5'd1, 1'b1);
        check("wp_ptr", Reg_Pointer, 5'd2);
        bus_event(1'b1, 1'b0, 1'b0);
        check("wp_mem1", mem[1], 8'h66);

        // Asynchronous reset in the middle of a write.
        addr_match(1'b0);
        rx_byte(8'h10);
        Slave_RxData  = 8'h77;
        Slave_RxValid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ptr", Reg_Pointer, 5'd0);
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_outs", {Slave_TxData, Slave_TxValid, RAM_RADD, RAM_WADD, RAM_DIN, RAM_W}, 32'd0);
        Slave_RxValid = 1'b0;
        tick();
        check("mid_rst_no_w", RAM_W, 1'b0);
        reset = 1'b1;
        tick();
        check("post_rst_busy", Busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_register_controller.md
Name: i2c_slave_register_controller

Overview:
- Responder-side companion to the I2C master controller: sits behind a byte-level I2C slave core and maps bus transactions onto a 32-entry x 8-bit register RAM.
- Master write: the first data byte sets the register pointer; later bytes are written to RAM with pointer auto-increment.
- Master read: bytes are streamed from RAM at the pointer, auto-incrementing, with one-byte prefetch.
- The pointer persists across transactions, so a 32-byte burst from address 0 round-trips cleanly.

Parameters:
NUM_REGS, 32, register count (power of two)
ADDR_WIDTH, 5, log2(NUM_REGS)
DATA_WIDTH, 8, byte width
RO_REGS, 1, registers 0..RO_REGS-1 read-only (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Slave_Start  input  1  pulse: START or repeated START detected
Slave_Stop  input  1  pulse: STOP detected
Slave_AddrMatch  input  1  pulse: own address received; Slave_RW valid this cycle
Slave_RW  input  1  1 = master read, 0 = master write
Slave_RxValid  input  1  pulse: Slave_RxData holds a byte from the master
Slave_RxData  input  8  received byte
Slave_TxReq  input  1  pulse: core needs next byte for the master
Slave_MasterNack  input  1  pulse: master NACKed the last transmitted byte
Slave_TxData  output  8  byte to transmit
Slave_TxValid  output  1  pulse: Slave_TxData valid for the pending Slave_TxReq
RAM_RADD  output  5  RAM read address (synchronous RAM, 1-cycle read latency)
RAM_RDOUT  input  8  RAM read data
RAM_WADD  output  5  RAM write address
RAM_DIN  output  8  RAM write data
RAM_W  output  1  RAM write strobe, one cycle per byte
Reg_Pointer  output  5  current register pointer
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pointer=0. All outputs 0: Slave_TxData, Slave_TxValid, RAM_RADD, RAM_WADD, RAM_DIN, RAM_W, Busy.
- States: IDLE, GET_POINTER, WRITE_DATA, READ_FETCH, READ_READY, READ_DONE.
- Priority per cycle: Slave_Stop > Slave_Start > Slave_AddrMatch > data events.
- IDLE:
  - AddrMatch & !RW -> GET_POINTER.
  - AddrMatch & RW -> READ_FETCH.
  - RxValid, TxReq and NACK are ignored.
- GET_POINTER: on RxValid, pointer <= RxData[4:0] (bits [7:5] ignored) -> WRITE_DATA. No RAM write for this byte.
- WRITE_DATA: on RxValid, next cycle RAM_WADD=pointer, RAM_DIN=RxData, RAM_W=1 for exactly one cycle; pointer <= pointer+1, so 31 wraps to 0.
- READ_FETCH:
  - Cycle after entry: RAM_RADD=pointer.
  - Following cycle: Slave_TxData <= RAM_RDOUT -> READ_READY.
  - A TxReq arriving during READ_FETCH is held pending, never dropped.
- READ_READY:
  - On TxReq (or a pending one): Slave_TxValid=1 for one cycle (next cycle); pointer <= pointer+1 (wrap) -> READ_FETCH to prefetch the next byte.
  - Latency TxReq->TxValid: 1 cycle when prefetched, at most 3 cycles when pending.
- READ_DONE: entered on Slave_MasterNack in READ_FETCH or READ_READY. Pointer remains one past the last sent byte; Slave_TxValid is not asserted again. Waits for Stop/Start.
- Slave_Stop in any state -> IDLE; Busy drops next cycle; pointer retained.
- Slave_Start in any non-IDLE state -> IDLE to await AddrMatch (repeated-start read after pointer write is supported).
- An in-flight RAM_W issued the cycle before Stop completes normally.
- Reset mid-transaction aborts immediately; a partial write is never completed.
- Reg_Pointer always reflects the internal pointer.

Optional Feature:
Macro I2C_SLAVE_WRITE_PROTECT_EN.
- Defined: a WRITE_DATA byte with pointer < RO_REGS produces no RAM_W pulse. The pointer still increments, and the byte is still ACKed by the core.
- Undefined: all NUM_REGS registers are writable; RO_REGS is unused.

Decomposition:
- Package i2c_slave_ctrl_pkg: state enumeration, NUM_REGS/ADDR_WIDTH constants, pointer wrap helper.
- Sub-module i2c_reg_pointer: load, increment and wrap counter with reset, instantiated once.

Test Plan:
- Reset: reset=0 mid-WRITE_DATA -> all outputs 0, state IDLE, Reg_Pointer=0.
- Write burst: AddrMatch RW=0, RxValid 0x1E, 0xAA, 0xBB, 0xCC -> RAM writes (30,0xAA), (31,0xBB), (0,0xCC), each RAM_W one cycle; Reg_Pointer=1.
- Read: pointer set to 5 by write then Stop, AddrMatch RW=1, RAM[5..7]=0x11,0x22,0x33, three TxReq -> TxData 0x11,0x22,0x33, each TxValid 1 cycle after TxReq once prefetched; NACK after third -> READ_DONE, pointer=8, no further TxValid.
- Early TxReq: TxReq in the same cycle as AddrMatch+1 -> TxValid with RAM[pointer] within 3 cycles, exactly one pulse.
- Repeated start: write pointer 0x03, Start, AddrMatch RW=1 -> first TxData=RAM[3]; Stop and Start together -> IDLE.
- I2C_SLAVE_WRITE_PROTECT_EN defined, RO_REGS=1: pointer 0, write 0x55, 0x66 -> no RAM_W for reg 0, RAM[1]=0x66.
